// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side hazard controller for the scalar and vector
// register files. Tracks destinations with writes in flight, blocks issue on
// RAW/WAW hazards or when the in-flight limit is reached, and releases busy
// bits from the shared writeback port.
//
// Ports:
//   clock, reset              clock and asynchronous active-low reset
//   flush                     synchronous clear of all tracking state
//   issueValid                decoded instruction wants to issue
//   src1Read/src2Read         operand reads, src*IsVector selects the file
//   reg1Address/reg2Address   source register addresses
//   writesScalar/writesVector destination file select
//   regDestinationAddress     destination register address
//   wbScalarValid/wbVectorValid, writeAddress  writeback port
//   stall, issueAccept        combinational issue decision
//   scalarBusy, vectorBusy    registered busy bitmaps
//   inflightCount             registered outstanding-write count
//   protocolError             sticky error flag
module reg_scoreboard #(
  parameter int unsigned SCALAR_REGNUM = 16,
  parameter int unsigned VECTOR_REGNUM = 16,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned MAX_INFLIGHT  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     issueValid,
  input  logic                     src1Read,
  input  logic                     src2Read,
  input  logic                     src1IsVector,
  input  logic                     src2IsVector,
  input  logic [ADDRESS_WIDTH-1:0] reg1Address,
  input  logic [ADDRESS_WIDTH-1:0] reg2Address,
  input  logic                     writesScalar,
  input  logic                     writesVector,
  input  logic [ADDRESS_WIDTH-1:0] regDestinationAddress,
  input  logic                     wbScalarValid,
  input  logic                     wbVectorValid,
  input  logic [ADDRESS_WIDTH-1:0] writeAddress,
  output logic                     stall,
  output logic                     issueAccept,
  output logic [SCALAR_REGNUM-1:0] scalarBusy,
  output logic [VECTOR_REGNUM-1:0] vectorBusy,
  output logic [3:0]               inflightCount,
  output logic                     protocolError
);

  localparam int unsigned CNT_W = 4;

  logic [SCALAR_REGNUM-1:0] scalar_busy_q, scalar_busy_d;
  logic [VECTOR_REGNUM-1:0] vector_busy_q, vector_busy_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     error_q, error_d;

  logic [SCALAR_REGNUM-1:0] wb_scalar_mask, eff_scalar;
  logic [VECTOR_REGNUM-1:0] wb_vector_mask, eff_vector;
  logic [1:0]               wb_cnt;
  logic                     src1_busy, src2_busy;
  logic                     raw_hazard, waw_hazard, cap_hazard, dual_dest;
  logic                     underflow;
  logic [CNT_W-1:0]         count_after_wb;

  // Writeback bypass: a register released this cycle is already readable
  // because the register files write on the falling edge.
  always_comb begin
    wb_scalar_mask = '0;
    wb_vector_mask = '0;
    if (wbScalarValid) wb_scalar_mask[writeAddress] = 1'b1;
    if (wbVectorValid) wb_vector_mask[writeAddress] = 1'b1;
    eff_scalar = scalar_busy_q & ~wb_scalar_mask;
    eff_vector = vector_busy_q & ~wb_vector_mask;
    wb_cnt     = 2'(wbScalarValid) + 2'(wbVectorValid);
  end

  // Hazard decision
  always_comb begin
    src1_busy  = src1IsVector ? eff_vector[reg1Address] : eff_scalar[reg1Address];
    src2_busy  = src2IsVector ? eff_vector[reg2Address] : eff_scalar[reg2Address];
    raw_hazard = (src1Read & src1_busy) | (src2Read & src2_busy);
    waw_hazard = (writesScalar & eff_scalar[regDestinationAddress]) |
                 (writesVector & eff_vector[regDestinationAddress]);
    // count - wb_cnt >= MAX rewritten to avoid unsigned wrap
    cap_hazard = (writesScalar | writesVector) &&
                 ({1'b0, count_q} >= (5'(MAX_INFLIGHT) + 5'(wb_cnt)));
    dual_dest  = writesScalar & writesVector;
    stall      = issueValid & (raw_hazard | waw_hazard | cap_hazard | dual_dest | flush);
    issueAccept = issueValid & ~stall;
  end

  // Next-state: flush, then writeback release, then issue set (set wins)
  always_comb begin
    scalar_busy_d  = scalar_busy_q;
    vector_busy_d  = vector_busy_q;
    count_d        = count_q;
    error_d        = error_q;
    underflow      = 1'b0;
    count_after_wb = count_q;

    if (flush) begin
      scalar_busy_d = '0;
      vector_busy_d = '0;
      count_d       = '0;
    end else begin
      underflow      = (count_q < {2'b00, wb_cnt});
      count_after_wb = underflow ? '0 : (count_q - {2'b00, wb_cnt});
      scalar_busy_d  = eff_scalar;
      vector_busy_d  = eff_vector;
      count_d        = count_after_wb;

      if (issueAccept && writesScalar) begin
        scalar_busy_d[regDestinationAddress] = 1'b1;
        count_d = count_after_wb + CNT_W'(1);
      end else if (issueAccept && writesVector) begin
        vector_busy_d[regDestinationAddress] = 1'b1;
        count_d = count_after_wb + CNT_W'(1);
      end

      if ((wbScalarValid && !scalar_busy_q[writeAddress]) ||
          (wbVectorValid && !vector_busy_q[writeAddress]) ||
          underflow || (issueValid && dual_dest)) begin
        error_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scalar_busy_q <= '0;
      vector_busy_q <= '0;
      count_q       <= '0;
      error_q       <= 1'b0;
    end else begin
      scalar_busy_q <= scalar_busy_d;
      vector_busy_q <= vector_busy_d;
      count_q       <= count_d;
      error_q       <= error_d;
    end
  end

  assign scalarBusy    = scalar_busy_q;
  assign vectorBusy    = vector_busy_q;
  assign inflightCount = count_q;
  assign protocolError = error_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed plus randomized stimulus for reg_scoreboard,
// checked against a behavioural model built from per-register busy arrays,
// an integer outstanding-write count and a sticky error bit.
module tb_reg_scoreboard;

  localparam int MAX = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush, issueValid;
  logic        src1Read, src2Read, src1IsVector, src2IsVector;
  logic [3:0]  reg1Address, reg2Address, regDestinationAddress, writeAddress;
  logic        writesScalar, writesVector, wbScalarValid, wbVectorValid;
  logic        stall, issueAccept, protocolError;
  logic [15:0] scalarBusy, vectorBusy;
  logic [3:0]  inflightCount;

  always #5 clock = ~clock;

  reg_scoreboard dut (
    .clock                 (clock),
    .reset                 (reset),
    .flush                 (flush),
    .issueValid            (issueValid),
    .src1Read              (src1Read),
    .src2Read              (src2Read),
    .src1IsVector          (src1IsVector),
    .src2IsVector          (src2IsVector),
    .reg1Address           (reg1Address),
    .reg2Address           (reg2Address),
    .writesScalar          (writesScalar),
    .writesVector          (writesVector),
    .regDestinationAddress (regDestinationAddress),
    .wbScalarValid         (wbScalarValid),
    .wbVectorValid         (wbVectorValid),
    .writeAddress          (writeAddress),
    .stall                 (stall),
    .issueAccept           (issueAccept),
    .scalarBusy            (scalarBusy),
    .vectorBusy            (vectorBusy),
    .inflightCount         (inflightCount),
    .protocolError         (protocolError)
  );

  // Reference model state
  bit sb[16];
  bit vb[16];
  int cnt;
  bit perr;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      sb[i] = 1'b0;
      vb[i] = 1'b0;
    end
    cnt  = 0;
    perr = 1'b0;
  endtask

  task automatic idle();
    flush = 0; issueValid = 0;
    src1Read = 0; src2Read = 0; src1IsVector = 0; src2IsVector = 0;
    reg1Address = 0; reg2Address = 0; regDestinationAddress = 0;
    writesScalar = 0; writesVector = 0;
    wbScalarValid = 0; wbVectorValid = 0; writeAddress = 0;
  endtask

  // Busy as seen by decode: released this cycle counts as free
  function automatic bit eff_busy(input bit is_vec, input int a);
    if (is_vec) return vb[a] && !(wbVectorValid && int'(writeAddress) == a);
    else        return sb[a] && !(wbScalarValid && int'(writeAddress) == a);
  endfunction

  function automatic bit model_stall();
    int wbn;
    bit s;
    if (!issueValid) return 1'b0;
    wbn = int'(wbScalarValid) + int'(wbVectorValid);
    s = 1'b0;
    if (src1Read && eff_busy(src1IsVector, int'(reg1Address))) s = 1'b1;
    if (src2Read && eff_busy(src2IsVector, int'(reg2Address))) s = 1'b1;
    if (writesScalar && eff_busy(1'b0, int'(regDestinationAddress))) s = 1'b1;
    if (writesVector && eff_busy(1'b1, int'(regDestinationAddress))) s = 1'b1;
    if ((writesScalar || writesVector) && (cnt - wbn >= MAX)) s = 1'b1;
    if (writesScalar && writesVector) s = 1'b1;
    if (flush) s = 1'b1;
    return s;
  endfunction

  task automatic model_update(input bit st);
    int wbn;
    bit acc;
    acc = issueValid && !st;
    if (flush) begin
      for (int i = 0; i < 16; i++) begin
        sb[i] = 1'b0;
        vb[i] = 1'b0;
      end
      cnt = 0;
    end else begin
      wbn = int'(wbScalarValid) + int'(wbVectorValid);
      if (wbScalarValid && !sb[writeAddress]) perr = 1'b1;
      if (wbVectorValid && !vb[writeAddress]) perr = 1'b1;
      if (wbn > cnt) perr = 1'b1;
      if (issueValid && writesScalar && writesVector) perr = 1'b1;
      cnt = (cnt > wbn) ? cnt - wbn : 0;
      if (wbScalarValid) sb[writeAddress] = 1'b0;
      if (wbVectorValid) vb[writeAddress] = 1'b0;
      if (acc && writesScalar) begin sb[regDestinationAddress] = 1'b1; cnt++; end
      else if (acc && writesVector) begin vb[regDestinationAddress] = 1'b1; cnt++; end
    end
  endtask

  task automatic check_regs(input string tag);
    logic [15:0] es, ev;
    for (int i = 0; i < 16; i++) begin
      es[i] = sb[i];
      ev[i] = vb[i];
    end
    chk({tag, ".scalarBusy"}, 32'(scalarBusy), 32'(es));
    chk({tag, ".vectorBusy"}, 32'(vectorBusy), 32'(ev));
    chk({tag, ".inflightCount"}, 32'(inflightCount), 32'(cnt));
    chk({tag, ".protocolError"}, 32'(protocolError), 32'(perr));
  endtask

  // Called at posedge+1 with inputs set; checks comb outputs, clocks, checks state
  task automatic cycle(input string tag);
    bit es;
    #2;
    es = model_stall();
    chk({tag, ".stall"}, 32'(stall), 32'(es));
    chk({tag, ".issueAccept"}, 32'(issueAccept), 32'(issueValid && !es));
    @(posedge clock);
    model_update(es);
    #1;
    check_regs(tag);
    idle();
  endtask

  task automatic issue_dest(input bit vec, input logic [3:0] d);
    issueValid = 1;
    regDestinationAddress = d;
    if (vec) writesVector = 1; else writesScalar = 1;
  endtask

  task automatic randomize_inputs();
    int start, a;
    bit found;
    int r;
    idle();
    issueValid   = ($urandom % 4) != 0;
    src1Read     = 1'($urandom);
    src2Read     = 1'($urandom);
    src1IsVector = 1'($urandom);
    src2IsVector = 1'($urandom);
    reg1Address  = 4'($urandom);
    reg2Address  = 4'($urandom);
    regDestinationAddress = 4'($urandom);
    r = int'($urandom % 64);
    if (r < 24) writesScalar = 1;
    else if (r < 48) writesVector = 1;
    else if (r == 63) begin writesScalar = 1; writesVector = 1; end
    flush = ($urandom % 32) == 0;
    start = int'($urandom % 16);
    a = start;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && (sb[(start + i) % 16] || vb[(start + i) % 16])) begin
        a = (start + i) % 16;
        found = 1'b1;
      end
    end
    writeAddress  = 4'(a);
    wbScalarValid = sb[a] && ($urandom % 2 == 0);
    wbVectorValid = vb[a] && ($urandom % 2 == 0);
    if ($urandom % 64 == 0) wbScalarValid = 1;
  endtask

  initial begin
    idle();
    model_reset();
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    check_regs("reset");
    chk("reset.stall", 32'(stall), 32'(0));
    reset = 1;

    // Scalar destination r5 becomes busy one cycle after acceptance
    issue_dest(0, 4'd5);
    cycle("issue_r5");
    chk("tp.busy_r5", 32'(scalarBusy), 32'h0020);
    chk("tp.count1", 32'(inflightCount), 32'd1);

    // RAW on r5, then same instruction with same-cycle release
    issueValid = 1; src1Read = 1; reg1Address = 5;
    cycle("raw_r5");
    issueValid = 1; src1Read = 1; reg1Address = 5;
    wbScalarValid = 1; writeAddress = 5;
    cycle("raw_r5_bypass");
    chk("tp.busy_cleared", 32'(scalarBusy), 32'h0000);

    // Vector v3 busy: scalar r3 read is fine, vector v3 write is WAW
    issue_dest(1, 4'd3);
    cycle("issue_v3");
    issueValid = 1; src1Read = 1; reg1Address = 3;
    cycle("read_r3");
    issue_dest(1, 4'd3);
    cycle("waw_v3");

    // Fill to the in-flight limit
    issue_dest(0, 4'd1); cycle("fill_r1");
    issue_dest(0, 4'd2); cycle("fill_r2");
    issue_dest(0, 4'd4); cycle("fill_r4");
    chk("tp.count4", 32'(inflightCount), 32'd4);
    issue_dest(0, 4'd6);
    cycle("cap_stall");
    issue_dest(0, 4'd6);
    wbVectorValid = 1; writeAddress = 3;
    cycle("cap_with_wb");
    chk("tp.count_stays4", 32'(inflightCount), 32'd4);

    // Writeback to non-busy v7, then flush
    wbVectorValid = 1; writeAddress = 7;
    cycle("wb_idle_v7");
    chk("tp.perr", 32'(protocolError), 32'd1);
    cycle("perr_sticky");
    flush = 1; issue_dest(0, 4'd9);
    cycle("flush");
    chk("tp.flush_count", 32'(inflightCount), 32'd0);

    // Asynchronous reset mid-cycle with three writes outstanding
    issue_dest(0, 4'd1); cycle("pre_rst_a");
    issue_dest(1, 4'd2); cycle("pre_rst_b");
    issue_dest(0, 4'd8); cycle("pre_rst_c");
    chk("tp.count3", 32'(inflightCount), 32'd3);
    #3 reset = 0;
    #1;
    model_reset();
    check_regs("async_reset");
    @(posedge clock);
    #1 reset = 1;

    // Randomized blocks, each preceded by a reset pulse
    for (int blk = 0; blk < 4; blk++) begin
      idle();
      reset = 0;
      #2;
      model_reset();
      reset = 1;
      check_regs("rand_reset");
      @(posedge clock);
      #1;
      for (int n = 0; n < 150; n++) begin
        randomize_inputs();
        cycle("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
